audio_transport_ctrl: RTL and testbench
=======================================

Name: audio_transport_ctrl

Overview:
Record/playback sequencer between the audio bus stream ports and the external 16-bit SRAM. In record mode it accepts 32-bit stereo samples (left in [31:16], right in [15:0]) and stores each one as two SRAM words. In play mode it reads those samples back and offers them as a 32-bit stream. Host commands are single-cycle pulses: start record, start play, pause/resume and stop. It tracks the recorded length and the current position.

Parameters:
ADDR_W, 20, SRAM word address width; sample capacity MAX_SAMPLES = 2^(ADDR_W-1).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_start_rec  in  1  pulse: start recording from sample 0
i_start_play  in  1  pulse: start playback from sample 0
i_pause  in  1  pulse: toggle pause
i_stop  in  1  pulse: abort current operation
record_audio_ready  out  1  sink ready for a recorded sample
record_audio_data  in  32  recorded sample {L,R}
record_audio_valid  in  1  recorded sample valid
play_audio_valid  out  1  playback sample valid
play_audio_data  out  32  playback sample {L,R}
play_audio_ready  in  1  playback sample consumed
sram_addr  out  ADDR_W  SRAM word address
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data, valid the cycle after the address is presented
sram_we_n  out  1  write enable, active-low
sram_oe_n  out  1  output enable, active-low
o_rec_len  out  ADDR_W  number of samples in the last recording
o_pos  out  ADDR_W  current sample index
o_busy  out  1  high in any state other than IDLE
o_paused  out  1  high in PAUSED
o_done  out  1  one-cycle pulse when an operation ends by itself (full or end of playback)

Behaviour:
- Reset (i_rst_n low, async): state IDLE.
  - record_audio_ready=0, play_audio_valid=0, play_audio_data=0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
  - o_rec_len=0, o_pos=0, o_busy=0, o_paused=0, o_done=0.
  - Reset mid-operation discards the sample in flight.
- States: IDLE, REC_WAIT, REC_WR_HI, REC_WR_LO, PLAY_RD_HI, PLAY_RD_LO, PLAY_LAT, PLAY_PRESENT, PAUSED.
- Command priority in one cycle: i_stop > i_pause > i_start_rec > i_start_play. Lower-priority commands in the same cycle are dropped.
- IDLE:
  - i_start_rec: o_pos=0, o_rec_len=0, go to REC_WAIT.
  - i_start_play: if o_rec_len=0, pulse o_done and stay in IDLE. Otherwise o_pos=0 and go to PLAY_RD_HI.
  - i_pause and i_stop are ignored.
- REC_WAIT: record_audio_ready=1 (registered, high the cycle after entry).
  - On valid&ready, latch the data, drop ready and go to REC_WR_HI.
  - REC_WR_HI: addr=2*pos, wdata=data[31:16], we_n=0.
  - REC_WR_LO: addr=2*pos+1, wdata=data[15:0], we_n=0. Then pos+1 and rec_len=pos+1.
  - After REC_WR_LO: if pos+1==MAX_SAMPLES, pulse o_done and go to IDLE. Otherwise return to REC_WAIT.
  - Minimum spacing between accepted samples is 3 cycles.
- Play sequence:
  - PLAY_RD_HI: addr=2*pos, oe_n=0.
  - PLAY_RD_LO: addr=2*pos+1, oe_n=0; latch rdata into data[31:16].
  - PLAY_LAT: latch rdata into data[15:0].
  - PLAY_PRESENT: play_audio_valid=1 with data stable until play_audio_ready is sampled high.
  - On ready: valid drops next cycle and pos+1. If pos+1==o_rec_len, pulse o_done and go to IDLE. Otherwise go to PLAY_RD_HI.
- i_pause:
  - In REC_WAIT or PLAY_PRESENT: go to PAUSED and remember the mode. ready/valid drop next cycle. An unconsumed play sample is kept and re-presented on resume.
  - In the write or read states: the pause takes effect at the next REC_WAIT/PLAY_PRESENT. Hold it as a pending flag.
  - In PAUSED: return to the remembered wait state.
  - i_start_* is ignored while in PAUSED.
- i_stop:
  - In REC_WAIT, PLAY_*, or PAUSED: go to IDLE next cycle with no o_done.
  - In REC_WR_HI/LO: finish the current word pair and update rec_len, then go to IDLE. A stored sample is never split.
- sram_we_n and sram_oe_n are never low in the same cycle. Both are high in IDLE and PAUSED.
- A start command while busy is ignored. Only i_stop or i_pause affect a running operation.

Test Plan:
- Record 3 samples 0xAAAA5555, 0x12345678, 0x0000FFFF, then i_stop -> SRAM words 0..5 = AAAA,5555,1234,5678,0000,FFFF; o_rec_len=3; no o_done.
- Play those 3 samples with play_audio_ready asserted 2 cycles after each valid -> stream 0xAAAA5555, 0x12345678, 0x0000FFFF in order; o_done pulses once after the 3rd; o_busy=0.
- i_start_play with o_rec_len=0 -> o_done pulses the next cycle; play_audio_valid never rises.
- ADDR_W=4 (MAX_SAMPLES=8), continuous record_audio_valid -> exactly 8 samples accepted; o_done fires; record_audio_ready stays 0.
- Pause during PLAY_PRESENT holding 0x12345678, wait 10 cycles, pause again -> the same 0x12345678 is re-presented; o_pos unchanged while paused.
- i_stop and i_start_rec in the same cycle while idle -> the block stays in IDLE. Deassert i_rst_n during REC_WR_HI -> all outputs reach their reset values immediately with no clock edge needed.

Source files
------------

// File: rtl/audio_transport_ctrl.sv
// Record/playback sequencer: stores 32-bit stereo samples as two 16-bit SRAM
// words and streams them back, with host start/pause/stop control.
module audio_transport_ctrl #(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic              record_audio_ready,
  input  logic [31:0]       record_audio_data,
  input  logic              record_audio_valid,
  output logic              play_audio_valid,
  output logic [31:0]       play_audio_data,
  input  logic              play_audio_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic [ADDR_W-1:0] o_pos,
  output logic              o_busy,
  output logic              o_paused,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] MAX_SAMPLES = {1'b1, {(ADDR_W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, REC_WAIT, REC_WR_HI, REC_WR_LO,
    PLAY_RD_HI, PLAY_RD_LO, PLAY_LAT, PLAY_PRESENT, PAUSED
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pos, pos_nx, rec_len, rec_len_nx, pos_inc;
  logic [31:0]       sample, sample_nx;
  logic              mode_play, mode_play_nx;
  logic              pause_pend, pause_pend_nx;
  logic              stop_pend, stop_pend_nx;
  logic              done, done_nx;
  logic              stop_after, pause_after;

  assign pos_inc     = pos + ADDR_W'(1);
  // Pending requests as they stand once this cycle's commands are folded in.
  assign stop_after  = stop_pend | i_stop;
  assign pause_after = pause_pend ^ (i_pause & ~i_stop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      pos        <= '0;
      rec_len    <= '0;
      sample     <= '0;
      mode_play  <= 1'b0;
      pause_pend <= 1'b0;
      stop_pend  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      pos        <= pos_nx;
      rec_len    <= rec_len_nx;
      sample     <= sample_nx;
      mode_play  <= mode_play_nx;
      pause_pend <= pause_pend_nx;
      stop_pend  <= stop_pend_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pos_nx        = pos;
    rec_len_nx    = rec_len;
    sample_nx     = sample;
    mode_play_nx  = mode_play;
    pause_pend_nx = pause_pend;
    stop_pend_nx  = stop_pend;
    done_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (i_stop || i_pause) begin
          state_nx = IDLE;
        end else if (i_start_rec) begin
          pos_nx        = '0;
          rec_len_nx    = '0;
          mode_play_nx  = 1'b0;
          pause_pend_nx = 1'b0;
          stop_pend_nx  = 1'b0;
          state_nx      = REC_WAIT;
        end else if (i_start_play) begin
          if (rec_len == '0) begin
            done_nx = 1'b1;
          end else begin
            pos_nx        = '0;
            mode_play_nx  = 1'b1;
            pause_pend_nx = 1'b0;
            stop_pend_nx  = 1'b0;
            state_nx      = PLAY_RD_HI;
          end
        end
      end
      REC_WAIT: begin
        if (i_stop) begin
          state_nx = IDLE;
        end else if (record_audio_valid) begin
          // Ready is high here, so the sample is already handed over; a
          // simultaneous pause waits until the pair is written.
          sample_nx     = record_audio_data;
          pause_pend_nx = i_pause;
          state_nx      = REC_WR_HI;
        end else if (i_pause) begin
          state_nx = PAUSED;
        end
      end
      REC_WR_HI: begin
        stop_pend_nx  = stop_after;
        pause_pend_nx = pause_after;
        state_nx      = REC_WR_LO;
      end
      REC_WR_LO: begin
        pos_nx        = pos_inc;
        rec_len_nx    = pos_inc;
        stop_pend_nx  = 1'b0;
        pause_pend_nx = 1'b0;
        if (stop_after)                state_nx = IDLE;
        else if (pos_inc == MAX_SAMPLES) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (pause_after)      state_nx = PAUSED;
        else                           state_nx = REC_WAIT;
      end
      PLAY_RD_HI, PLAY_RD_LO: begin
        if (i_stop) begin
          state_nx = IDLE;
        end else begin
          pause_pend_nx = pause_after;
          if (state == PLAY_RD_LO) begin
            sample_nx[31:16] = sram_rdata;
            state_nx         = PLAY_LAT;
          end else begin
            state_nx = PLAY_RD_LO;
          end
        end
      end
      PLAY_LAT: begin
        if (i_stop) begin
          state_nx = IDLE;
        end else begin
          sample_nx[15:0] = sram_rdata;
          pause_pend_nx   = 1'b0;
          state_nx        = pause_after ? PAUSED : PLAY_PRESENT;
        end
      end
      PLAY_PRESENT: begin
        if (i_stop) begin
          state_nx = IDLE;
        end else if (play_audio_ready) begin
          pos_nx = pos_inc;
          if (pos_inc == rec_len) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            pause_pend_nx = i_pause;
            state_nx      = PLAY_RD_HI;
          end
        end else if (i_pause) begin
          state_nx = PAUSED;
        end
      end
      PAUSED: begin
        if (i_stop)       state_nx = IDLE;
        else if (i_pause) state_nx = mode_play ? PLAY_PRESENT : REC_WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state)
      REC_WR_HI: begin
        sram_addr  = {pos[ADDR_W-2:0], 1'b0};
        sram_wdata = sample[31:16];
        sram_we_n  = 1'b0;
      end
      REC_WR_LO: begin
        sram_addr  = {pos[ADDR_W-2:0], 1'b1};
        sram_wdata = sample[15:0];
        sram_we_n  = 1'b0;
      end
      PLAY_RD_HI: begin
        sram_addr = {pos[ADDR_W-2:0], 1'b0};
        sram_oe_n = 1'b0;
      end
      PLAY_RD_LO: begin
        sram_addr = {pos[ADDR_W-2:0], 1'b1};
        sram_oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign record_audio_ready = (state == REC_WAIT);
  assign play_audio_valid   = (state == PLAY_PRESENT);
  assign play_audio_data    = sample;
  assign o_rec_len          = rec_len;
  assign o_pos              = pos;
  assign o_busy             = (state != IDLE);
  assign o_paused           = (state == PAUSED);
  assign o_done             = done;

endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Directed bench for audio_transport_ctrl at ADDR_W=4 (8-sample capacity)
// with a small synchronous SRAM model.
module tb_audio_transport_ctrl;

  localparam int AW = 4;

  logic          i_clk, i_rst_n;
  logic          i_start_rec, i_start_play, i_pause, i_stop;
  logic          record_audio_ready, record_audio_valid;
  logic [31:0]   record_audio_data;
  logic          play_audio_valid, play_audio_ready;
  logic [31:0]   play_audio_data;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata, sram_rdata;
  logic          sram_we_n, sram_oe_n;
  logic [AW-1:0] o_rec_len, o_pos;
  logic          o_busy, o_paused, o_done;

  audio_transport_ctrl #(.ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_start_rec(i_start_rec), .i_start_play(i_start_play),
    .i_pause(i_pause), .i_stop(i_stop),
    .record_audio_ready(record_audio_ready), .record_audio_data(record_audio_data),
    .record_audio_valid(record_audio_valid),
    .play_audio_valid(play_audio_valid), .play_audio_data(play_audio_data),
    .play_audio_ready(play_audio_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .o_rec_len(o_rec_len), .o_pos(o_pos), .o_busy(o_busy),
    .o_paused(o_paused), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // SRAM: read data appears the cycle after the address.
  logic [15:0] mem [16];
  always @(posedge i_clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_wdata;
    if (!sram_oe_n) sram_rdata <= mem[sram_addr];
  end

  int done_cnt = 0, vld_cnt = 0, acc_cnt = 0;
  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (play_audio_valid) vld_cnt++;
    if (record_audio_ready && record_audio_valid) acc_cnt++;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 12; k++) begin
      if (play_audio_valid) break;
      cyc();
    end
    check(name, 64'(play_audio_valid), 64'd1);
  endtask

  typedef struct {
    logic        rec, play, pause, stop, rvalid;
    logic [31:0] rdata;
    logic        busy, ready, we_n;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [3:0]  pos, len;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] play_exp [3];
  logic [34:0] act_v, exp_v;
  int d0, v0, a0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //               rec  play pause stop rvld rdata          busy rdy  we_n addr  wdata     pos   len
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,4'd0,16'h0000,4'd0,4'd0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hAAAA5555, 1'b1,1'b0,1'b0,4'd0,16'hAAAA,4'd0,4'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,4'd1,16'h5555,4'd0,4'd0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,4'd0,16'h0000,4'd1,4'd1};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h12345678, 1'b1,1'b0,1'b0,4'd2,16'h1234,4'd1,4'd1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,4'd3,16'h5678,4'd1,4'd1};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,4'd0,16'h0000,4'd2,4'd2};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000FFFF, 1'b1,1'b0,1'b0,4'd4,16'h0000,4'd2,4'd2};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,4'd5,16'hFFFF,4'd2,4'd2};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,4'd0,16'h0000,4'd3,4'd3};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,4'd0,16'h0000,4'd3,4'd3};
    play_exp[0] = 32'hAAAA5555;
    play_exp[1] = 32'h12345678;
    play_exp[2] = 32'h0000FFFF;

    i_rst_n = 1'b0;
    i_start_rec = 1'b0; i_start_play = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    record_audio_valid = 1'b0; record_audio_data = 32'h0; play_audio_ready = 1'b0;
    cyc(); cyc();
    check("reset_state",
          {record_audio_ready, play_audio_valid, play_audio_data, sram_we_n, sram_oe_n,
           sram_addr, sram_wdata, o_rec_len, o_pos, o_busy, o_paused, o_done},
          {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    i_rst_n = 1'b1;
    cyc();

    // Play with nothing recorded.
    d0 = done_cnt; v0 = vld_cnt;
    i_start_play = 1'b1; cyc(); i_start_play = 1'b0;
    check("empty_play_done", {o_done, o_busy}, {1'b1, 1'b0});
    cyc();
    check("empty_play_done_clear", 64'(o_done), 64'd0);
    repeat (3) cyc();
    check("empty_play_no_valid", 64'(vld_cnt - v0), 64'd0);
    check("empty_play_one_done", 64'(done_cnt - d0), 64'd1);

    // Stop outranks start_rec.
    i_stop = 1'b1; i_start_rec = 1'b1; cyc(); i_stop = 1'b0; i_start_rec = 1'b0;
    check("stop_vs_start_idle", {o_busy, record_audio_ready}, 2'b00);
    cyc();
    check("stop_vs_start_idle2", 64'(o_busy), 64'd0);

    // Record three samples, then stop.
    d0 = done_cnt;
    for (int i = 0; i < 11; i++) begin
      i_start_rec = tbl[i].rec; i_start_play = tbl[i].play;
      i_pause = tbl[i].pause; i_stop = tbl[i].stop;
      record_audio_valid = tbl[i].rvalid; record_audio_data = tbl[i].rdata;
      cyc();
      act_v = {o_busy, record_audio_ready, sram_we_n, sram_addr, sram_wdata, o_pos, o_rec_len,
               o_done, play_audio_valid, sram_oe_n, o_paused};
      exp_v = {tbl[i].busy, tbl[i].ready, tbl[i].we_n, tbl[i].addr, tbl[i].wdata,
               tbl[i].pos, tbl[i].len, 1'b0, 1'b0, 1'b1, 1'b0};
      check($sformatf("rec_vec%0d", i), 64'(act_v), 64'(exp_v));
    end
    i_stop = 1'b0; record_audio_valid = 1'b0; record_audio_data = 32'h0;
    cyc();
    check("rec_no_done", 64'(done_cnt - d0), 64'd0);
    check("sram_words",
          {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]},
          {16'hAAAA, 16'h5555, 16'h1234, 16'h5678, 16'h0000, 16'hFFFF});

    // Play back, consuming each sample two cycles after valid.
    d0 = done_cnt;
    i_start_play = 1'b1; cyc(); i_start_play = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_valid($sformatf("play_valid%0d", s));
      check($sformatf("play_data%0d", s), 64'(play_audio_data), 64'(play_exp[s]));
      cyc(); cyc();
      check($sformatf("play_hold%0d", s), {play_audio_valid, play_audio_data}, {1'b1, play_exp[s]});
      play_audio_ready = 1'b1; cyc(); play_audio_ready = 1'b0;
      check($sformatf("play_valid_drop%0d", s), 64'(play_audio_valid), 64'd0);
    end
    cyc(); cyc();
    check("play_end", {done_cnt - d0, 4'(o_busy), o_pos}, {32'd1, 4'd0, 4'd3});

    // Pause while presenting the second sample.
    d0 = done_cnt;
    i_start_play = 1'b1; cyc(); i_start_play = 1'b0;
    wait_valid("pause_first_valid");
    play_audio_ready = 1'b1; cyc(); play_audio_ready = 1'b0;
    wait_valid("pause_second_valid");
    check("pause_before", {play_audio_data, o_pos}, {32'h12345678, 4'd1});
    i_pause = 1'b1; cyc(); i_pause = 1'b0;
    check("paused_enter", {o_paused, play_audio_valid, o_busy, sram_oe_n, sram_we_n}, 5'b10111);
    v0 = vld_cnt;
    repeat (10) cyc();
    check("paused_hold", {o_paused, o_pos, 8'(vld_cnt - v0)}, {1'b1, 4'd1, 8'd0});
    i_pause = 1'b1; cyc(); i_pause = 1'b0;
    check("resume_represent", {o_paused, play_audio_valid, play_audio_data, o_pos},
          {1'b0, 1'b1, 32'h12345678, 4'd1});
    i_stop = 1'b1; cyc(); i_stop = 1'b0;
    cyc();
    check("pause_stop_idle", {o_busy, play_audio_valid, 4'(done_cnt - d0)}, {1'b0, 1'b0, 4'd0});

    // Fill the whole capacity with valid held high.
    d0 = done_cnt; a0 = acc_cnt;
    record_audio_valid = 1'b1; record_audio_data = 32'h5A5AA5A5;
    i_start_rec = 1'b1; cyc(); i_start_rec = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (o_done) break;
      cyc();
    end
    check("full_done", {o_done, o_busy, o_rec_len, o_pos}, {1'b1, 1'b0, 4'd8, 4'd8});
    repeat (3) begin
      cyc();
      check("full_ready_low", 64'(record_audio_ready), 64'd0);
    end
    check("full_accepted", {acc_cnt - a0, done_cnt - d0}, {32'd8, 32'd1});
    check("full_last_words", {mem[14], mem[15]}, {16'h5A5A, 16'hA5A5});

    // Asynchronous reset in the middle of a write pair.
    record_audio_data = 32'hDEADBEEF;
    i_start_rec = 1'b1; cyc(); i_start_rec = 1'b0;
    cyc();
    record_audio_valid = 1'b0;
    check("wr_hi_before_reset", {sram_we_n, sram_addr, sram_wdata}, {1'b0, 4'd0, 16'hDEAD});
    #2 i_rst_n = 1'b0;
    #1;
    check("async_reset",
          {record_audio_ready, play_audio_valid, play_audio_data, sram_we_n, sram_oe_n,
           sram_addr, sram_wdata, o_rec_len, o_pos, o_busy, o_paused, o_done},
          {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
